// File: rtl/mon_pkg.sv
// Shared command/reply bytes, state encoding and address width for the boot monitor.
package mon_pkg;

  localparam int ADDR_W = 9;

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] RPL_OK   = 8'h2E;
  localparam logic [7:0] RPL_HALT = 8'h48;
  localparam logic [7:0] RPL_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    WDATA,
    RSET,
    RWAIT,
    RSEND,
    RUN,
    REPLY
  } mon_state_e;

endpackage

// File: rtl/mon_port_mux.sv
// Ownership mux: hands the RAM and UART tx ports to the CPU while it is running.
module mon_port_mux
  import mon_pkg::*;
(
  input  logic              running,
  input  logic [ADDR_W-1:0] mon_raddr,
  input  logic [ADDR_W-1:0] mon_waddr,
  input  logic [7:0]        mon_dwrite,
  input  logic              mon_we,
  input  logic [7:0]        mon_tx_byte,
  input  logic              mon_transmit,
  input  logic [ADDR_W-1:0] cpu_raddr,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [7:0]        cpu_dwrite,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_tx_byte,
  input  logic              cpu_transmit,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_dwrite,
  output logic              ram_we,
  output logic [7:0]        tx_byte,
  output logic              transmit
);

  assign ram_raddr  = running ? cpu_raddr    : mon_raddr;
  assign ram_waddr  = running ? cpu_waddr    : mon_waddr;
  assign ram_dwrite = running ? cpu_dwrite   : mon_dwrite;
  assign ram_we     = running ? cpu_we       : mon_we;
  assign tx_byte    = running ? cpu_tx_byte  : mon_tx_byte;
  assign transmit   = running ? cpu_transmit : mon_transmit;

endmodule

// File: rtl/boot_monitor.sv
// Boot/debug monitor: UART write/read/go protocol owning RAM and tx while the CPU is idle.
// Define MON_TIMEOUT_EN to abort half-received commands after TIMEOUT_CYCLES of silence.
module boot_monitor
  import mon_pkg::*;
#(
  parameter int RD_LAT         = 2,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              received,
  input  logic [7:0]        rx_byte,
  input  logic              is_transmitting,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_dread,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_dwrite,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] cpu_raddr,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [7:0]        cpu_dwrite,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_tx_byte,
  input  logic              cpu_transmit,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] cpu_startaddr,
  input  logic              cpu_halted,
  output logic              running
);

  localparam int WAIT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  if (RD_LAT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("boot_monitor: RD_LAT and TIMEOUT_CYCLES must be at least 1");
  end

  mon_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        reply_q, reply_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] startaddr_q, startaddr_d;
  logic              running_q, running_d;

  logic              mon_we;
  logic [7:0]        mon_dwrite;
  logic              mon_transmit;
  logic [7:0]        mon_tx_byte;
  logic              tmo_hit;

`ifdef MON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             in_cmd;

  // Only mid-command states are timed; RUN and the reply/read phases never abort.
  assign in_cmd  = state_q inside {ADDR_HI, ADDR_LO, LEN, WDATA};
  assign tmo_hit = in_cmd && !received && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_cmd || received || tmo_hit) tmo_cnt_q <= '0;
    else                                       tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cmd_q       <= '0;
      reply_q     <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
      start_q     <= 1'b0;
      startaddr_q <= '0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      reply_q     <= reply_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      start_q     <= start_d;
      startaddr_q <= startaddr_d;
      running_q   <= running_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cmd_d        = cmd_q;
    reply_d      = reply_q;
    rdata_d      = rdata_q;
    wait_d       = wait_q;
    start_d      = 1'b0;
    startaddr_d  = startaddr_q;
    running_d    = running_q;
    mon_we       = 1'b0;
    mon_transmit = 1'b0;
    mon_tx_byte  = 8'h00;
    unique case (state_q)
      IDLE: if (received) begin
        if (rx_byte == CMD_W || rx_byte == CMD_R || rx_byte == CMD_G) begin
          cmd_d   = rx_byte;
          state_d = ADDR_HI;
        end else begin
          reply_d = RPL_ERR;
          state_d = REPLY;
        end
      end
      ADDR_HI: if (received) begin
        addr_d[ADDR_W-1] = rx_byte[0];
        state_d          = ADDR_LO;
      end
      ADDR_LO: if (received) begin
        addr_d[7:0] = rx_byte;
        if (cmd_q == CMD_G) begin
          start_d     = 1'b1;
          startaddr_d = {addr_q[ADDR_W-1], rx_byte};
          running_d   = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = LEN;
        end
      end
      LEN: if (received) begin
        len_d   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        state_d = (cmd_q == CMD_W) ? WDATA : RSET;
      end
      WDATA: if (received) begin
        mon_we = 1'b1;
        addr_d = addr_q + 1'b1;
        len_d  = len_q - 1'b1;
        if (len_q == 9'd1) begin
          reply_d = RPL_OK;
          state_d = REPLY;
        end
      end
      RSET: begin
        wait_d  = '0;
        state_d = RWAIT;
      end
      // ram_raddr tracks addr_q, so the data is valid on the RD_LAT-th wait cycle
      RWAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          rdata_d = ram_dread;
          state_d = RSEND;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RSEND: begin
        mon_tx_byte = rdata_q;
        if (!is_transmitting) begin
          mon_transmit = 1'b1;
          addr_d       = addr_q + 1'b1;
          len_d        = len_q - 1'b1;
          state_d      = (len_q == 9'd1) ? IDLE : RSET;
        end
      end
      RUN: if (cpu_halted) begin
        running_d = 1'b0;
        reply_d   = RPL_HALT;
        state_d   = REPLY;
      end
      REPLY: begin
        mon_tx_byte = reply_q;
        if (!is_transmitting) begin
          mon_transmit = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      reply_d = RPL_ERR;
      state_d = REPLY;
    end
  end

  assign mon_dwrite    = mon_we ? rx_byte : 8'h00;
  assign cpu_start     = start_q;
  assign cpu_startaddr = startaddr_q;
  assign running       = running_q;

  mon_port_mux u_mux (
    .running      (running_q),
    .mon_raddr    (addr_q),
    .mon_waddr    (addr_q),
    .mon_dwrite   (mon_dwrite),
    .mon_we       (mon_we),
    .mon_tx_byte  (mon_tx_byte),
    .mon_transmit (mon_transmit),
    .cpu_raddr    (cpu_raddr),
    .cpu_waddr    (cpu_waddr),
    .cpu_dwrite   (cpu_dwrite),
    .cpu_we       (cpu_we),
    .cpu_tx_byte  (cpu_tx_byte),
    .cpu_transmit (cpu_transmit),
    .ram_raddr    (ram_raddr),
    .ram_waddr    (ram_waddr),
    .ram_dwrite   (ram_dwrite),
    .ram_we       (ram_we),
    .tx_byte      (tx_byte),
    .transmit     (transmit)
  );

endmodule

// File: tb/tb_boot_monitor.sv
// Directed bench for boot_monitor with a 2-cycle-latency RAM model and a busy-window UART model.
module tb_boot_monitor;
  import mon_pkg::*;

  logic       clk = 1'b0;
  logic       rst, received, is_transmitting, transmit, ram_we, cpu_we, cpu_transmit;
  logic       cpu_start, cpu_halted, running, tx_hold;
  logic [7:0] rx_byte, tx_byte, ram_dread, ram_dwrite, cpu_dwrite, cpu_tx_byte;
  logic [8:0] ram_raddr, ram_waddr, cpu_raddr, cpu_waddr, cpu_startaddr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  boot_monitor #(.RD_LAT(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .ram_raddr(ram_raddr), .ram_dread(ram_dread), .ram_waddr(ram_waddr),
    .ram_dwrite(ram_dwrite), .ram_we(ram_we), .cpu_raddr(cpu_raddr),
    .cpu_waddr(cpu_waddr), .cpu_dwrite(cpu_dwrite), .cpu_we(cpu_we),
    .cpu_tx_byte(cpu_tx_byte), .cpu_transmit(cpu_transmit), .cpu_start(cpu_start),
    .cpu_startaddr(cpu_startaddr), .cpu_halted(cpu_halted), .running(running)
  );

  // RAM with two registered read stages
  logic [7:0] mem [512];
  logic [7:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_dwrite;
    rd_p1 <= mem[ram_raddr];
    rd_p2 <= rd_p1;
  end
  assign ram_dread = rd_p2;

  // UART stays busy for 6 cycles after each strobe; tx_hold forces busy
  logic [3:0] busy_cnt = 4'd0;
  always @(posedge clk) begin
    if (transmit)           busy_cnt <= 4'd6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign is_transmitting = tx_hold || (busy_cnt != 4'd0);

  // Log monitor-side writes and transmits; flag strobe protocol violations
  logic [16:0] wr_q [$];
  logic [7:0]  tx_q [$];
  int   viol = 0;
  logic prev_tx = 1'b0, prev_we = 1'b0;
  always @(negedge clk) begin
    if (!running) begin
      if (ram_we)   wr_q.push_back({ram_waddr, ram_dwrite});
      if (transmit) tx_q.push_back(tx_byte);
      if ((transmit && (prev_tx || is_transmitting)) || (ram_we && prev_we)) viol <= viol + 1;
    end
    prev_tx <= transmit;
    prev_we <= ram_we;
  end

  function automatic logic [17:0] wr_at(input int i);
    if (i < wr_q.size()) return {1'b0, wr_q[i]};
    return 18'h3FFFF;
  endfunction

  function automatic logic [8:0] tx_at(input int i);
    if (i < tx_q.size()) return {1'b0, tx_q[i]};
    return 9'h1FF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    tick();
    received = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_cmd(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      tick();
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_vec++; if (transmit !== 1'b0 || tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx: got %b/%h want 0/00", transmit, tx_byte); end
    n_vec++; if (ram_we !== 1'b0 || ram_dwrite !== 8'h00) begin n_err++; $display("FAIL reset_ram_w: got %b/%h want 0/00", ram_we, ram_dwrite); end
    n_vec++; if (ram_raddr !== 9'h000 || ram_waddr !== 9'h000) begin n_err++; $display("FAIL reset_ram_addr: got %h/%h want 000/000", ram_raddr, ram_waddr); end
    n_vec++; if (cpu_start !== 1'b0 || cpu_startaddr !== 9'h000) begin n_err++; $display("FAIL reset_cpu: got %b/%h want 0/000", cpu_start, cpu_startaddr); end
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    int bw = wr_q.size();
    int bt = tx_q.size();
    logic [16:0] exp_w [3];
    exp_w = '{17'h010AA, 17'h011BB, 17'h012CC};
    send_cmd('{CMD_W, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 7);
    wait_tx(bt + 1, 100);
    n_vec++; if (wr_q.size() - bw != 3) begin n_err++; $display("FAIL write_count: got %0d want 3", wr_q.size() - bw); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (wr_at(bw + i) !== {1'b0, exp_w[i]}) begin n_err++; $display("FAIL write_data%0d: got %h want %h", i, wr_at(bw + i), exp_w[i]); end
    end
    n_vec++; if (tx_at(bt) !== 9'h02E) begin n_err++; $display("FAIL write_reply: got %h want 02E", tx_at(bt)); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL write_strobes: got %0d violations want 0", viol); end
  endtask

  task automatic test_read();
    int bt = tx_q.size();
    logic [7:0] exp_t [3];
    exp_t = '{8'hAA, 8'hBB, 8'hCC};
    idle(10);
    tx_hold = 1'b1;
    send_cmd('{CMD_R, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    idle(10);
    n_vec++; if (tx_q.size() != bt) begin n_err++; $display("FAIL read_busy_hold: got %0d bytes want 0", tx_q.size() - bt); end
    tx_hold = 1'b0;
    wait_tx(bt + 3, 200);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (tx_at(bt + i) !== {1'b0, exp_t[i]}) begin n_err++; $display("FAIL read_byte%0d: got %h want %h", i, tx_at(bt + i), exp_t[i]); end
    end
    idle(30);
    n_vec++; if (tx_q.size() != bt + 3) begin n_err++; $display("FAIL read_no_trailer: got %0d bytes want 3", tx_q.size() - bt); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL read_strobes: got %0d violations want 0", viol); end
  endtask

  task automatic test_wrap();
    int bw = wr_q.size();
    int bt = tx_q.size();
    idle(10);
    send_cmd('{CMD_W, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00}, 6);
    wait_tx(bt + 1, 100);
    n_vec++; if (wr_at(bw) !== 18'h01FF11) begin n_err++; $display("FAIL wrap_write0: got %h want 01FF11", wr_at(bw)); end
    n_vec++; if (wr_at(bw + 1) !== 18'h000022) begin n_err++; $display("FAIL wrap_write1: got %h want 000022", wr_at(bw + 1)); end
    n_vec++; if (tx_at(bt) !== 9'h02E) begin n_err++; $display("FAIL wrap_reply: got %h want 02E", tx_at(bt)); end
    idle(10);
    send_cmd('{CMD_R, 8'h01, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    wait_tx(bt + 3, 200);
    n_vec++; if (tx_at(bt + 1) !== 9'h011 || tx_at(bt + 2) !== 9'h022) begin n_err++; $display("FAIL wrap_read: got %h %h want 011 022", tx_at(bt + 1), tx_at(bt + 2)); end
  endtask

  task automatic test_go();
    int bt = tx_q.size();
    idle(10);
    send_cmd('{CMD_G, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    send_byte(8'h20);
    n_vec++; if (cpu_start !== 1'b1 || running !== 1'b1) begin n_err++; $display("FAIL go_start: got start=%b run=%b want 1/1", cpu_start, running); end
    n_vec++; if (cpu_startaddr !== 9'h020) begin n_err++; $display("FAIL go_addr: got %h want 020", cpu_startaddr); end
    tick();
    n_vec++; if (cpu_start !== 1'b0 || cpu_startaddr !== 9'h020) begin n_err++; $display("FAIL go_pulse: got %b/%h want 0/020", cpu_start, cpu_startaddr); end
    cpu_we = 1'b1; cpu_waddr = 9'h055; cpu_dwrite = 8'h77; cpu_raddr = 9'h0AB;
    cpu_tx_byte = 8'h99; cpu_transmit = 1'b1;
    #1;
    n_vec++; if ({ram_we, ram_waddr, ram_dwrite, ram_raddr} !== {1'b1, 9'h055, 8'h77, 9'h0AB}) begin n_err++; $display("FAIL go_ram_pass: got %b %h %h %h want 1 055 77 0AB", ram_we, ram_waddr, ram_dwrite, ram_raddr); end
    n_vec++; if (transmit !== 1'b1 || tx_byte !== 8'h99) begin n_err++; $display("FAIL go_tx_pass: got %b/%h want 1/99", transmit, tx_byte); end
    tick();
    cpu_we = 1'b0; cpu_transmit = 1'b0;
    idle(2);
    send_byte(8'h5A);
    idle(3);
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL go_halt_running: got %b want 0", running); end
    wait_tx(bt + 1, 100);
    n_vec++; if (tx_at(bt) !== 9'h048) begin n_err++; $display("FAIL go_halt_reply: got %h want 048", tx_at(bt)); end
    idle(10);
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    idle(20);
    n_vec++; if (tx_q.size() != bt + 1 || cpu_startaddr !== 9'h020) begin n_err++; $display("FAIL go_idle_halt: got %0d bytes addr %h want 1 020", tx_q.size() - bt, cpu_startaddr); end
  endtask

  task automatic test_unknown();
    int bt = tx_q.size();
    idle(10);
    send_byte(8'h5A);
    wait_tx(bt + 1, 50);
    n_vec++; if (tx_at(bt) !== 9'h03F) begin n_err++; $display("FAIL unknown_reply: got %h want 03F", tx_at(bt)); end
  endtask

  task automatic test_reset_mid();
    int bw;
    int bt;
    idle(10);
    bw = wr_q.size();
    bt = tx_q.size();
    send_cmd('{CMD_W, 8'h00, 8'h40, 8'h04, 8'hD1, 8'hD2, 8'h00, 8'h00}, 6);
    rst = 1'b1;
    tick();
    n_vec++; if ({running, transmit, ram_we, ram_waddr} !== 12'h000) begin n_err++; $display("FAIL rst_wdata: got %b %b %b %h want 0 0 0 000", running, transmit, ram_we, ram_waddr); end
    rst = 1'b0;
    idle(20);
    n_vec++; if (tx_q.size() != bt || wr_q.size() != bw + 2) begin n_err++; $display("FAIL rst_wdata_quiet: got tx %0d wr %0d want 0 2", tx_q.size() - bt, wr_q.size() - bw); end
    send_byte(8'h5A);
    wait_tx(bt + 1, 50);
    n_vec++; if (tx_at(bt) !== 9'h03F) begin n_err++; $display("FAIL rst_wdata_idle: got %h want 03F", tx_at(bt)); end
    idle(10);
    send_cmd('{CMD_G, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL rst_run_entry: got %b want 1", running); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if ({running, cpu_start, cpu_startaddr} !== 11'h000) begin n_err++; $display("FAIL rst_run: got %b %b %h want 0 0 000", running, cpu_start, cpu_startaddr); end
    cpu_we = 1'b1; cpu_waddr = 9'h077; cpu_transmit = 1'b1;
    #1;
    n_vec++; if (ram_we !== 1'b0 || transmit !== 1'b0) begin n_err++; $display("FAIL rst_run_mask: got we=%b tx=%b want 0/0", ram_we, transmit); end
    tick();
    cpu_we = 1'b0; cpu_transmit = 1'b0;
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    idle(20);
    n_vec++; if (tx_q.size() != bt + 1) begin n_err++; $display("FAIL rst_run_quiet: got %0d bytes want 1", tx_q.size() - bt); end
  endtask

  task automatic test_timeout();
    int bt = tx_q.size();
    int c = 0;
    idle(10);
    send_byte(CMD_W);
    tick();
    send_byte(8'h00);
`ifdef MON_TIMEOUT_EN
    while (tx_q.size() == bt && c < 300) begin
      tick();
      c++;
    end
    n_vec++; if (tx_at(bt) !== 9'h03F) begin n_err++; $display("FAIL timeout_reply: got %h want 03F", tx_at(bt)); end
    n_vec++; if (c < 100 || c > 102) begin n_err++; $display("FAIL timeout_delay: got %0d cycles want 100..102", c); end
`else
    while (tx_q.size() == bt && c < 150) begin
      tick();
      c++;
    end
    n_vec++; if (tx_q.size() != bt) begin n_err++; $display("FAIL no_timeout: got %0d bytes after %0d cycles want 0", tx_q.size() - bt, c); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    idle(5);
  endtask

  initial begin
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00; tx_hold = 1'b0;
    cpu_raddr = '0; cpu_waddr = '0; cpu_dwrite = '0; cpu_we = 1'b0;
    cpu_tx_byte = '0; cpu_transmit = 1'b0; cpu_halted = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_go();
    test_unknown();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_monitor.md
Name: boot_monitor

Overview:
- Serial boot/debug controller that owns the 512-byte program RAM and the UART whenever the CPU is idle.
- Accepts a byte-level command protocol over UART: write RAM, read RAM, go.
- On go, it starts the CPU at a given address and hands it RAM and UART ownership until the CPU's one-cycle halted pulse, then reclaims both.
- Sits between the UART, the RAM, and the cpu core.

Parameters:
- ADDR_W, 9, RAM address width (512 bytes).
- RD_LAT, 2, cycles from registered raddr to valid ram_dread.
- TIMEOUT_CYCLES, 1200000, inter-byte timeout; used only with MON_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- received  in  1  UART rx strobe, one cycle, rx_byte valid.
- rx_byte  in  8  UART received byte.
- is_transmitting  in  1  UART tx busy.
- tx_byte  out  8  byte to UART tx (muxed).
- transmit  out  1  UART tx strobe (muxed).
- ram_raddr  out  9  RAM read address (muxed).
- ram_dread  in  8  RAM read data.
- ram_waddr  out  9  RAM write address (muxed).
- ram_dwrite  out  8  RAM write data (muxed).
- ram_we  out  1  RAM write enable (muxed).
- cpu_raddr / cpu_waddr  in  9 each  CPU RAM addresses.
- cpu_dwrite  in  8  CPU RAM write data.
- cpu_we  in  1  CPU RAM write enable.
- cpu_tx_byte  in  8  CPU UART tx byte.
- cpu_transmit  in  1  CPU UART tx strobe.
- cpu_start  out  1  one-cycle start pulse to the CPU's start/rst input.
- cpu_startaddr  out  9  CPU start address, held stable from the cpu_start pulse onward.
- cpu_halted  in  1  CPU halt pulse.
- running  out  1  high while the CPU owns RAM/UART.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address, length and reply registers 0.
- Ownership mux:
  - running=1: RAM and tx ports pass the cpu_* inputs through combinationally.
  - running=0: ports are driven from monitor registers.
- Received bytes while running are ignored by the monitor; the CPU consumes them itself.
- Commands (addr = {hi[0], lo}; hi[7:1] ignored):
  - 'W' 0x57, hi, lo, len, then len data bytes.
  - 'R' 0x52, hi, lo, len.
  - 'G' 0x47, hi, lo.
  - len=0 means 256.
  - Any other first byte: reply '?' 0x3F.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, RSET, RWAIT, RSEND, RUN, REPLY.
- IDLE: on received, decode the command byte. W/R/G go to ADDR_HI; unknown goes to REPLY with '?'.
- ADDR_LO:
  - G: assert cpu_start for one cycle, latch cpu_startaddr, set running, go to RUN.
  - W/R: go to LEN.
- WDATA: each received byte writes at the current address in that same cycle (ram_we=1 for one cycle), then address increments mod 512 and the count decrements. After the last byte, go to REPLY with '.' 0x2E.
- Read sequence:
  - RSET: drive ram_raddr.
  - RWAIT: hold RD_LAT cycles, then capture ram_dread.
  - RSEND: wait for !is_transmitting, pulse transmit with the byte, increment address mod 512.
  - Repeat until the count is exhausted, then return to IDLE with no trailer.
- RUN: on cpu_halted, clear running the same cycle the pulse is seen and go to REPLY with 'H' 0x48.
- REPLY: wait for !is_transmitting, pulse transmit, go to IDLE.
- Address wrap: 0x1FF+1 -> 0x000, for both W and R.
- Simultaneous events:
  - received during REPLY or RSEND: the byte is dropped; the protocol is half-duplex.
  - cpu_halted while not in RUN: ignored.
- Reset mid-operation, including RUN: return to IDLE, running=0, no reply sent. The CPU itself is not reset by this block; its later RAM/UART activity is masked.
- transmit and ram_we are never high for more than one consecutive cycle from the monitor side.

Optional Feature:
- Macro: MON_TIMEOUT_EN.
- Enabled:
  - A counter restarts on each received byte in ADDR_HI..WDATA.
  - Reaching TIMEOUT_CYCLES aborts the command and goes to REPLY with '?'.
  - Partial writes already done remain in RAM.
  - RUN is never timed out.
- Disabled: no counter; the monitor waits indefinitely mid-command.

Decomposition:
- Package mon_pkg holds:
  - command/reply byte constants (CMD_W, CMD_R, CMD_G, RPL_OK, RPL_HALT, RPL_ERR);
  - the state enumeration;
  - ADDR_W.
- One sub-module, mon_port_mux: the combinational ownership mux for RAM and tx, selected by running.

Test Plan:
- 'W' 00 10 03 AA BB CC -> ram writes 0x010=AA, 0x011=BB, 0x012=CC, one ram_we per byte, then tx '.' 0x2E.
- 'R' 00 10 03 after the above -> tx AA, BB, CC in order, each transmit only when is_transmitting=0.
- 'W' 01 FF 02 11 22 -> writes 0x1FF=11 and 0x000=22 (wrap), tx '.'.
- 'G' 00 20 -> cpu_start single pulse, cpu_startaddr=0x020, running=1, cpu_we/cpu_tx pass-through. Then inject cpu_halted -> running=0 and tx 'H' 0x48.
- Byte 0x5A in IDLE -> tx '?' 0x3F.
- rst asserted mid-WDATA and mid-RUN -> next cycle IDLE, running=0, transmit=0, ram_we=0.
- With MON_TIMEOUT_EN and TIMEOUT_CYCLES=100: 'W' 00, then silence -> tx '?' at 100 cycles.
